// File: rtl/dmem_responder.sv
// dmem_responder
//
// Word-addressed data memory on the memory side of the core's MEM stage.
// Accepts one load/store request at a time, waits WAIT_STATES cycles, then
// answers with a one-cycle dReady pulse carrying read data or an error flag.
// Misaligned, out-of-range and read/write-conflicting requests are flagged
// and never modify the array.
//
// Parameters:
//   BASE_ADDR   byte address of word 0 (word aligned)
//   DEPTH_WORDS number of 32-bit words, power of two, 4..65536
//   WAIT_STATES cycles between accept and response, 0..15
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   MemRead     read request strobe (level)
//   MemWrite    write request strobe (level)
//   dAddress    byte address
//   dWriteData  store data
//   dReadData   load data, held until the next read response
//   dReady      one-cycle response pulse
//   dError      request rejected, valid only with dReady
//   busy        request in flight (WAIT or RESP)
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dError,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;

  logic [31:0]        rdata_q;
  logic               ready_q;
  logic               error_q;
  logic               busy_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  // Request decode. BASE_ADDR is word aligned, so subtracting at word
  // granularity gives the same word offset as the full byte subtraction;
  // addresses below the base wrap to huge offsets and fail the range check.
  logic [29:0]        word_off;
  logic               req;
  logic               req_err;

  assign word_off = dAddress[31:2] - BASE_ADDR[31:2];
  assign req      = MemRead | MemWrite;
  assign req_err  = (MemRead & MemWrite) | (|dAddress[1:0]) |
                    (word_off >= 30'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = word_off[IDX_W-1:0];
          wdata_d = dWriteData;
          // Conflicts are neither a read nor a write: they must leave both
          // the array and dReadData untouched.
          rd_d    = MemRead & ~MemWrite;
          wr_d    = MemWrite & ~MemRead;
          err_d   = req_err;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state so they line up with the
  // state they describe without any input-to-output combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      ready_q <= (state_d == S_RESP);
      error_q <= (state_d == S_RESP) & err_d;
      busy_q  <= (state_d != S_IDLE);
      // Load data is captured on the edge entering RESP (RESP always exits
      // to IDLE, so state_d == S_RESP marks exactly that edge).
      if ((state_d == S_RESP) && rd_d) begin
        rdata_q <= err_d ? 32'd0 : mem_q[idx_d];
      end
    end
  end

  // The store commits on the edge leaving RESP; an asynchronous reset
  // forces IDLE first, so a pending store is dropped.
  always_ff @(posedge clk) begin
    if ((state_q == S_RESP) && wr_q && !err_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign dReadData = rdata_q;
  assign dReady    = ready_q;
  assign dError    = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd, wr, rdy, er, bsy;
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] rdata [3];

  always #5 clk = ~clk;

  // Three instances: default wait states, zero and maximum.
  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .MemRead(rd[0]), .MemWrite(wr[0]), .dAddress(ad[0]),
    .dWriteData(wd[0]), .dReadData(rdata[0]), .dReady(rdy[0]), .dError(er[0]), .busy(bsy[0]));
  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .MemRead(rd[1]), .MemWrite(wr[1]), .dAddress(ad[1]),
    .dWriteData(wd[1]), .dReadData(rdata[1]), .dReady(rdy[1]), .dError(er[1]), .busy(bsy[1]));
  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .rst(rst), .MemRead(rd[2]), .MemWrite(wr[2]), .dAddress(ad[2]),
    .dWriteData(wd[2]), .dReadData(rdata[2]), .dReady(rdy[2]), .dError(er[2]), .busy(bsy[2]));

  int          wsv [3];
  logic [31:0] mem_m [3][DEPTH];
  logic [31:0] exp_rd [3];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One request on instance k, starting in an IDLE cycle (#1 after an edge).
  // Model: error if both strobes, misaligned, or (addr-BASE)/4 >= DEPTH.
  task automatic do_req(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input string tag);
    logic [31:0] off;
    bit          errx;
    int          idx;
    int          n;
    off  = a - BASE;
    errx = (r && w) || (a % 4 != 0) || ((off / 4) >= 32'(DEPTH));
    idx  = errx ? 0 : int'(off / 4);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    n = 1;
    while (n <= 40 && !rdy[k]) begin
      check($sformatf("%s busy_wait", tag), 32'(bsy[k]), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[k]) begin
      check($sformatf("%s timeout", tag), 32'(rdy[k]), 32'd1);
      rd[k] = 1'b0; wr[k] = 1'b0;
      return;
    end
    if (r && !w) exp_rd[k] = errx ? 32'd0 : mem_m[k][idx];
    if (w && !r && !errx) mem_m[k][idx] = d;
    check($sformatf("%s latency", tag), 32'(n), 32'(wsv[k] + 1));
    check($sformatf("%s busy_resp", tag), 32'(bsy[k]), 32'd1);
    check($sformatf("%s error", tag), 32'(er[k]), 32'(errx));
    check($sformatf("%s rdata", tag), rdata[k], exp_rd[k]);
    if (!hold) begin
      rd[k] = 1'b0; wr[k] = 1'b0;
    end
    @(posedge clk); #1;
    check($sformatf("%s ready_drop", tag), 32'(rdy[k]), 32'd0);
    check($sformatf("%s busy_drop", tag), 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] word;
    int          sel;
    int          typ;
    wsv[0] = 1; wsv[1] = 0; wsv[2] = 15;
    rst = 1'b0;
    rd = '0; wr = '0;
    for (int k = 0; k < 3; k++) begin
      ad[k] = 32'd0; wd[k] = 32'd0; exp_rd[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d rdata", k), rdata[k], 32'd0);
      check($sformatf("reset%0d ready", k), 32'(rdy[k]), 32'd0);
      check($sformatf("reset%0d error", k), 32'(er[k]), 32'd0);
      check($sformatf("reset%0d busy", k), 32'(bsy[k]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill every word of every instance so later reads have known contents.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++)
        do_req(k, 1'b0, 1'b1, BASE + 32'(i * 4), $urandom, 1'b0, "fill");

    // Write then read back, default wait states.
    do_req(0, 1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 1'b0, "wr_dead");
    do_req(0, 1'b1, 1'b0, 32'h10010004, 32'd0, 1'b0, "rd_dead");
    check("rd_dead value", rdata[0], 32'hDEADBEEF);

    // Latency extremes.
    do_req(1, 1'b1, 1'b0, BASE + 32'd8, 32'd0, 1'b0, "ws0_rd");
    do_req(2, 1'b1, 1'b0, BASE + 32'd8, 32'd0, 1'b0, "ws15_rd");

    // Error cases.
    do_req(0, 1'b1, 1'b0, 32'h10010002, 32'd0, 1'b0, "misalign_rd");
    check("misalign_rd zero", rdata[0], 32'd0);
    do_req(0, 1'b0, 1'b1, 32'h0FFFFFFC, 32'h12345678, 1'b0, "below_wr");
    do_req(0, 1'b1, 1'b0, BASE, 32'd0, 1'b0, "word0_rd");
    do_req(0, 1'b0, 1'b1, 32'h10010400, 32'h0BADF00D, 1'b0, "oor_wr");
    do_req(0, 1'b0, 1'b1, 32'h100103FC, 32'hCAFEF00D, 1'b0, "last_wr");
    do_req(0, 1'b1, 1'b0, 32'h100103FC, 32'd0, 1'b0, "last_rd");
    check("last_rd value", rdata[0], 32'hCAFEF00D);
    do_req(0, 1'b1, 1'b1, BASE + 32'd16, 32'h55AA55AA, 1'b0, "conflict");
    check("conflict rdata_kept", rdata[0], 32'hCAFEF00D);
    do_req(0, 1'b1, 1'b0, BASE + 32'd16, 32'd0, 1'b0, "after_conflict_rd");

    // Strobe held through RESP: second request taken in the next IDLE cycle.
    do_req(0, 1'b1, 1'b0, BASE + 32'd20, 32'd0, 1'b1, "held1");
    do_req(0, 1'b1, 1'b0, BASE + 32'd24, 32'd0, 1'b0, "held2");
    do_req(1, 1'b1, 1'b0, BASE + 32'd28, 32'd0, 1'b1, "held_ws0_1");
    do_req(1, 1'b1, 1'b0, BASE + 32'd32, 32'd0, 1'b0, "held_ws0_2");

    // Randomized traffic against the model.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 60; i++) begin
        sel  = $urandom_range(0, 9);
        typ  = $urandom_range(0, 9);
        word = 32'($urandom_range(0, DEPTH - 1));
        case (sel)
          0:       a = BASE + word * 4 + 32'($urandom_range(1, 3));
          1:       a = BASE + 32'((DEPTH + $urandom_range(0, 1000)) * 4);
          2:       a = BASE - 32'($urandom_range(1, 100) * 4);
          default: a = BASE + word * 4;
        endcase
        do_req(k, (typ == 0) || (typ < 5), (typ == 0) || (typ >= 5), a, $urandom, 1'b0, "rand");
      end
    end

    // Reset in the middle of a write's wait period on word 3.
    wr[2] = 1'b1; ad[2] = BASE + 32'd12; wd[2] = ~mem_m[2][3];
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("midwait busy", 32'(bsy[2]), 32'd1);
    rst = 1'b0;
    wr[2] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
    check("abort ready", 32'(rdy[2]), 32'd0);
    check("abort busy", 32'(bsy[2]), 32'd0);
    check("abort error", 32'(er[2]), 32'd0);
    check("abort rdata", rdata[2], 32'd0);
    check("abort rdata_ws1", rdata[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(2, 1'b1, 1'b0, BASE + 32'd12, 32'd0, 1'b0, "post_abort_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
